// File: rtl/mult8s_booth4_pp_stage_pkg.sv
// Shared types and constants for the radix-4 Booth partial-product stage.
// Holds the digit encoding, the size localparams and the sign-correction constant.
package mult_pkg;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  localparam int MULT_WIDTH = 8;
  localparam int PP_COUNT   = MULT_WIDTH / 2;
  localparam int ROW_W      = 2 * MULT_WIDTH;

  // Each partial product has its sign bit inverted in place.
  // That contributes an extra +2^(width+2i), so subtract all of those once.
  function automatic logic [63:0] sign_corr(input int width);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < width / 2; i++) begin
      acc = acc - (64'd1 << (width + 2 * i));
    end
    return acc;
  endfunction

endpackage

// File: rtl/mult8s_booth4_pp_stage_enc.sv
// One radix-4 Booth digit: recodes three multiplier bits and forms the
// WIDTH+1-bit partial product (ones' complement when negative) plus its negate bit.
module booth4_enc
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       bits,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH:0]   pp,
  output logic             neg
);

  booth_digit_t dig;
  logic [WIDTH:0] mag;

  always_comb begin
    dig.neg = bits[2];
    dig.one = bits[1] ^ bits[0];
    dig.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
    mag = '0;
    if (dig.one) begin
      mag = {a[WIDTH-1], a};
    end else if (dig.two) begin
      mag = {a, 1'b0};
    end
    // A -0 digit (bits 111) yields all ones plus a negate bit, which sums to zero.
    pp  = mag ^ {(WIDTH + 1){dig.neg}};
    neg = dig.neg;
  end

endmodule

// File: rtl/mult8s_booth4_pp_stage.sv
// Two-stage signed multiplier front end: S1 registers Booth partial products,
// S2 compresses them to two carry-save rows for a downstream carry-propagate adder.
module mult8s_booth4_pp_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_row0,
  output logic [2*WIDTH-1:0]   out_row1,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PPN = WIDTH / 2;
  localparam int RW  = 2 * WIDTH;
  localparam logic [63:0]   CORR64 = sign_corr(WIDTH);
  localparam logic [RW-1:0] CORR   = CORR64[RW-1:0];

  logic [WIDTH:0]   pp_next [PPN];
  logic [PPN-1:0]   neg_next;
  logic [WIDTH:0]   pp_reg  [PPN];
  logic [PPN-1:0]   neg_reg;
  logic [TAG_W-1:0] tag1_reg;
  logic             s1_valid_reg;

  logic [RW-1:0]    row0_reg, row1_reg;
  logic [TAG_W-1:0] tag2_reg;
  logic             s2_valid_reg;

  logic s1_adv, s2_adv;
  logic [WIDTH:0] b_ext;

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign b_ext    = {in_b, 1'b0};

  for (genvar gi = 0; gi < PPN; gi++) begin : g_enc
    booth4_enc #(.WIDTH(WIDTH)) u_enc (
      .bits (b_ext[2*gi+2 -: 3]),
      .a    (in_a),
      .pp   (pp_next[gi]),
      .neg  (neg_next[gi])
    );
  end

  // S2 rows: one per partial product, plus one merged row holding the negate
  // bits (positions below WIDTH) and the correction constant (bits WIDTH and up).
  logic [RW-1:0] row [PPN+1];
  logic [RW-1:0] neg_row;

  for (genvar gi = 0; gi < PPN; gi++) begin : g_row
    assign row[gi] = {{(RW-WIDTH-1){1'b0}}, ~pp_reg[gi][WIDTH], pp_reg[gi][WIDTH-1:0]} << (2 * gi);
  end

  always_comb begin
    neg_row = '0;
    for (int i = 0; i < PPN; i++) begin
      neg_row[2*i] = neg_reg[i];
    end
  end

  assign row[PPN] = CORR | neg_row;

  logic [RW-1:0] sum_c   [PPN];
  logic [RW-1:0] carry_c [PPN];

  assign sum_c[0]   = row[0];
  assign carry_c[0] = row[1];

  // Linear chain of 3:2 compressors; carries out of the top bit are dropped (mod 2^RW).
  for (genvar gi = 1; gi < PPN; gi++) begin : g_csa
    assign sum_c[gi]   = sum_c[gi-1] ^ carry_c[gi-1] ^ row[gi+1];
    assign carry_c[gi] = {(sum_c[gi-1][RW-2:0] & carry_c[gi-1][RW-2:0]) |
                          (sum_c[gi-1][RW-2:0] & row[gi+1][RW-2:0]) |
                          (carry_c[gi-1][RW-2:0] & row[gi+1][RW-2:0]), 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      neg_reg      <= '0;
      tag1_reg     <= '0;
      row0_reg     <= '0;
      row1_reg     <= '0;
      tag2_reg     <= '0;
      for (int i = 0; i < PPN; i++) begin
        pp_reg[i] <= '0;
      end
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          neg_reg  <= neg_next;
          tag1_reg <= in_tag;
          for (int i = 0; i < PPN; i++) begin
            pp_reg[i] <= pp_next[i];
          end
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          row0_reg <= sum_c[PPN-1];
          row1_reg <= carry_c[PPN-1];
          tag2_reg <= tag1_reg;
        end
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_row0  = row0_reg;
  assign out_row1  = row1_reg;
  assign out_tag   = tag2_reg;

endmodule
